// File: rtl/rv32i_types_pkg.sv
// Shared sequencer types: FSM encoding, lane count and an enable popcount helper.
package rv32i_types_pkg;

   localparam int VSEQ_LANES = 2;

   typedef enum logic [1:0] {
      VSEQ_IDLE  = 2'd0,
      VSEQ_ISSUE = 2'd1,
      VSEQ_WAIT  = 2'd2,
      VSEQ_DONE  = 2'd3
   } vseq_state_t;

   function automatic logic [5:0] vseq_popcnt(input logic [VSEQ_LANES-1:0] ena);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < VSEQ_LANES; i++) begin
         n = n + 6'(ena[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// Issue handshake, pipeline control and lane-pair outputs of the vector lane sequencer.
interface vector_lane_sequencer_if;

   logic        issue_valid;
   logic        issue_ready;
   logic [5:0]  vl;
   logic        is_masked;
   logic [31:0] mask_bits;
   logic        stall_e_m;
   logic        flush;
   logic        lane_busy;
   logic        lane_start;
   logic [4:0]  lane_offset0;
   logic [4:0]  lane_offset1;
   logic        lane_ena0;
   logic        lane_ena1;
   logic        done;
   logic [5:0]  issued_cnt;

   modport master (
      output issue_valid, vl, is_masked, mask_bits, stall_e_m, flush, lane_busy,
      input  issue_ready, lane_start, lane_offset0, lane_offset1,
             lane_ena0, lane_ena1, done, issued_cnt
   );

   modport slave (
      input  issue_valid, vl, is_masked, mask_bits, stall_e_m, flush, lane_busy,
      output issue_ready, lane_start, lane_offset0, lane_offset1,
             lane_ena0, lane_ena1, done, issued_cnt
   );

endinterface

// File: rtl/vector_lane_sequencer.sv
// Walks a vector op over two lanes in element pairs: 2 cycles/pair + 1 DONE cycle; holds on stall/lane_busy.
// VECTOR_SEQ_MASK_SKIP_EN: fully-masked pairs skip the lane start and the WAIT state.
module vector_lane_sequencer
   import rv32i_types_pkg::*;
(
   input  logic                   CLK,
   input  logic                   nRST,
   vector_lane_sequencer_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = VSEQ_IDLE;
   localparam logic [1:0] ST_ISSUE = VSEQ_ISSUE;
   localparam logic [1:0] ST_WAIT  = VSEQ_WAIT;
   localparam logic [1:0] ST_DONE  = VSEQ_DONE;

`ifdef VECTOR_SEQ_MASK_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic [1:0]  state;
   logic [5:0]  base;
   logic [5:0]  vl_q;
   logic        masked_q;
   logic [31:0] mask_q;
   logic [5:0]  cnt;

   logic        active;
   logic [5:0]  off0;
   logic [5:0]  off1;
   logic [5:0]  base_adv;
   logic        ena0;
   logic        ena1;
   logic        skip;
   logic        fire;

   always_comb begin
      active   = (state == ST_ISSUE) || (state == ST_WAIT);
      off0     = base;
      off1     = base + 6'd1;
      base_adv = base + 6'd2;
      ena0     = active && (off0 < vl_q) && (!masked_q || mask_q[off0[4:0]]);
      ena1     = active && (off1 < vl_q) && (!masked_q || mask_q[off1[4:0]]);
      skip     = SKIP_EN && !ena0 && !ena1;
      fire     = (state == ST_ISSUE) && !bus.stall_e_m;
   end

   assign bus.issue_ready  = (state == ST_IDLE) && !bus.flush;
   assign bus.lane_start   = fire && !skip;
   assign bus.lane_offset0 = active ? off0[4:0] : 5'd0;
   assign bus.lane_offset1 = active ? off1[4:0] : 5'd0;
   assign bus.lane_ena0    = ena0;
   assign bus.lane_ena1    = ena1;
   assign bus.done         = (state == ST_DONE);
   assign bus.issued_cnt   = cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= ST_IDLE;
         base     <= '0;
         vl_q     <= '0;
         masked_q <= 1'b0;
         mask_q   <= '0;
         cnt      <= '0;
      end else if (bus.flush) begin
         state <= ST_IDLE;
         base  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.issue_valid) begin
                  // Clamp keeps base bounded at 32 even for an out-of-range vl.
                  vl_q     <= (bus.vl > 6'd32) ? 6'd32 : bus.vl;
                  masked_q <= bus.is_masked;
                  mask_q   <= bus.mask_bits;
                  base     <= '0;
                  cnt      <= '0;
                  state    <= (bus.vl == 6'd0) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (fire) begin
                  if (skip) begin
                     base  <= base_adv;
                     state <= (base_adv >= vl_q) ? ST_DONE : ST_ISSUE;
                  end else begin
                     cnt   <= cnt + vseq_popcnt({ena1, ena0});
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.lane_busy && !bus.stall_e_m) begin
                  base  <= base_adv;
                  state <= (base_adv >= vl_q) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
